nat_conn_table: RTL and testbench
=================================

// Module: nat_conn_table
// PURPOSE
//  Parametrised successor of the NAT tuple-to-connection stage. Collects a 5-tuple over a
//  DATA_W-wide valid/ready stream, finds it in a hashed connection table (linear probing) or
//  inserts it, and returns a slot-based connection ID. Adds configurable bus width, table depth
//  and probe limit, plus new-entry/full status, occupancy count and table flush.
// PARAMETERS
//  DATA_W     32    tuple beat width; legal values 32, 64 or 128; BEATS = 128/DATA_W
//  DEPTH      1024  table entries; power of 2, >=4; IDX_W = $clog2(DEPTH)
//  PROBE_MAX  32    max slots probed per lookup, 1..DEPTH
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous, active-high reset
//  tuple_valid_i  in   1       tuple beat valid
//  tuple_data_i   in   DATA_W  tuple beat
//  tuple_ready_o  out  1       beat accepted when valid&ready
//  flush_i        in   1       request: invalidate every table entry
//  conn_valid_o   out  1       result valid
//  conn_data_o    out  32      [31]=hit_or_alloc, [30]=new, [IDX_W-1:0]=conn id, others 0
//  conn_ready_i   in   1       result consumed when valid&ready
//  occupancy_o    out  IDX_W+1 number of valid entries
// BEHAVIOUR
//  - Key K (104b) = {proto[7:0], dst_port, src_port, dst_ip, src_ip}; beat k carries
//    {24'b0,K}[k*DATA_W +: DATA_W]. DATA_W=32 order: src_ip, dst_ip, {dst_port,src_port}, {24'b0,proto}.
//    Bits 127:104 of the last beat are ignored.
//  - Reset: tuple_ready_o=1, conn_valid_o=0, conn_data_o=0, occupancy_o=0, all valid bits 0,
//    beat counter 0, flush_pend 0, FSM=COLLECT. Reset mid-lookup/mid-response aborts with no write.
//  - FSM: COLLECT -> HASH -> READ -> CMP -> (READ | RESP) -> COLLECT.
//    COLLECT: tuple_ready_o=1 unless flush_pend; after the BEATS-th accepted beat go HASH.
//    HASH: idx <= XOR-fold of K into IDX_W-bit chunks (zero-padded top chunk); probes=0.
//    READ: key RAM read at idx (1-cycle sync read); valid bit sampled from flop vector.
//    CMP: slot valid & key==K -> hit: data={1,0,idx}. Slot empty -> write K, set valid,
//      occupancy+1, data={1,1,idx}. Else probes+1; if probes+1==PROBE_MAX -> full:
//      data=32'h0, no write; otherwise idx=(idx+1) mod DEPTH (wraps DEPTH-1 -> 0), go READ.
//    RESP: conn_valid_o=1, conn_data_o held stable until conn_valid_o&conn_ready_i, then COLLECT.
//  - Latency last beat -> conn_valid_o: 4 + 2*(probes-1) cycles (4 on first-slot hit/insert).
//  - tuple_ready_o=0 outside COLLECT; no beats accepted during lookup or response.
//  - Same key always returns same ID until flush; distinct keys never share an ID.
//  - flush_i: sets flush_pend in any state. In COLLECT with flush_pend: tuple_ready_o=0 that
//    cycle, all valid bits and occupancy cleared, beat counter zeroed (partial tuple discarded),
//    flush_pend cleared. A beat accepted in the same cycle flush_i rises is discarded too.
//    flush_i during a lookup does not alter that lookup's result.
//  - occupancy_o saturates at DEPTH (cannot exceed: inserts only into empty slots).
// STRUCTURE
//  - nat_pkg: TUPLE_W=104, field offsets, result bit positions (RES_OK=31, RES_NEW=30),
//    function nat_fold_hash(key, idx_w), FSM state encoding.
//  - Sub-module nat_key_ram: DEPTH x 104 single-port RAM, sync read, write-first-not-required
//    (read and write never hit the same cycle). Valid vector and FSM stay in nat_conn_table.
// TESTING (DATA_W=32, DEPTH=16, PROBE_MAX=4 unless noted)
//  1 Reset, send A={0x0A000000,0x08080808,1234,80,6} -> 0x80000000|0x40000000|h(A), occ=1;
//    resend A -> 0x80000000|h(A) (new=0), occ=1; latency 4 cycles from last beat.
//  2 B=A but src_ip 0x0A000011 (same fold) -> id=(h(A)+1)&15, new=1; resend B -> same id, 6-cycle latency.
//  3 Tuple with h=15 and slot 15 occupied -> id=0 (wrap-around), new=1.
//  4 Five same-hash keys -> first four allocated ids h..h+3, fifth -> conn_data_o=32'h0, occ=4.
//  5 conn_ready_i low 10 cycles -> conn_valid_o and data stable, tuple_ready_o=0; flush_i
//    mid-beat-2 -> partial discarded, occ=0, resend A -> new=1.
//  6 DATA_W=64/128, DEPTH=1024, PROBE_MAX=32: 1024 random tuples, 50% repeats -> same key
//    same id, different keys different ids, never full; rst asserted mid-lookup -> occ=0.

Source files
------------

// File: rtl/nat_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nat_pkg
//  Purpose  : Shared constants, FSM encoding and the tuple fold hash used by
//             the NAT connection table.
//  Revision : 1.0 - initial release
// ============================================================================
package nat_pkg;

  // Packed 5-tuple width and field offsets inside the key
  localparam int TUPLE_W      = 104;
  localparam int SRC_IP_LSB   = 0;
  localparam int DST_IP_LSB   = 32;
  localparam int SRC_PORT_LSB = 64;
  localparam int DST_PORT_LSB = 80;
  localparam int PROTO_LSB    = 96;

  // Result word bit positions
  localparam int RES_OK  = 31;
  localparam int RES_NEW = 30;

  // Lookup FSM encoding
  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_HASH    = 3'd1,
    ST_READ    = 3'd2,
    ST_CMP     = 3'd3,
    ST_RESP    = 3'd4
  } nat_state_t;

  // XOR-fold of the key into idx_w-bit chunks; key bit i lands on bit (i mod idx_w),
  // which is the same as XOR-ing zero-padded idx_w-bit slices together.
  function automatic logic [31:0] nat_fold_hash(input logic [TUPLE_W-1:0] key, input int idx_w);
    logic [31:0] h;
    logic [4:0]  pos;
    h = '0;
    for (int i = 0; i < TUPLE_W; i++) begin
      pos    = 5'(i % idx_w);
      h[pos] = h[pos] ^ key[i];
    end
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nat_key_ram.sv
`default_nettype none
// ============================================================================
//  Module   : nat_key_ram
//  Purpose  : DEPTH x WIDTH single-port key store with one-cycle synchronous
//             read. Reads and writes are never issued in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module nat_key_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 104,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single port: a write takes the port, otherwise an enabled read registers the slot
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/nat_conn_table.sv
`default_nettype none
// ============================================================================
//  Module   : nat_conn_table
//  Purpose  : Collects a 5-tuple over a valid/ready stream, looks it up in a
//             linear-probing hash table (inserting on miss) and returns the
//             slot index as connection ID, with new/full status, occupancy
//             count and table flush.
//  Revision : 1.0 - initial release
// ============================================================================
module nat_conn_table
  import nat_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int PROBE_MAX = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tuple_valid_i,
  input  logic [DATA_W-1:0]        tuple_data_i,
  output logic                     tuple_ready_o,
  input  logic                     flush_i,
  output logic                     conn_valid_o,
  output logic [31:0]              conn_data_o,
  input  logic                     conn_ready_i,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int BEATS = 128 / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PRB_W = $clog2(PROBE_MAX + 1);

  nat_state_t          state, state_nxt;
  logic [CNT_W-1:0]    beat_cnt;
  logic [127:0]        key_buf;
  logic [TUPLE_W-1:0]  key;
  logic [127-TUPLE_W:0] unused_pad;
  logic [IDX_W-1:0]    idx;
  logic [PRB_W-1:0]    probes;
  logic [DEPTH-1:0]    valid_vec;
  logic [IDX_W:0]      occ;
  logic                flush_pend;
  logic                slot_valid;
  logic [31:0]         res;
  logic [31:0]         id_word;

  logic                ram_en, ram_we;
  logic [TUPLE_W-1:0]  ram_rdata;

  logic take_beat, last_beat, slot_hit, slot_empty, probe_last;

  // Bits above the 104-bit key in the last beat carry no information
  assign key        = key_buf[TUPLE_W-1:0];
  assign unused_pad = key_buf[127:TUPLE_W];

  // A beat arriving together with a flush request is dropped along with the partial tuple
  assign take_beat  = tuple_valid_i & tuple_ready_o & ~flush_i;
  assign last_beat  = (beat_cnt == CNT_W'(BEATS - 1));
  assign slot_hit   = slot_valid & (ram_rdata == key);
  assign slot_empty = ~slot_valid;
  assign probe_last = ((probes + PRB_W'(1)) == PRB_W'(PROBE_MAX));
  assign id_word    = 32'(idx);

  nat_key_ram #(
    .DEPTH (DEPTH),
    .WIDTH (TUPLE_W)
  ) u_key_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (idx),
    .wdata (key),
    .rdata (ram_rdata)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_COLLECT;
    else     state <= state_nxt;
  end

  // FSM next-state: collect beats, hash, then alternate read/compare until resolved
  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: if (take_beat && last_beat) state_nxt = ST_HASH;
      ST_HASH:    state_nxt = ST_READ;
      ST_READ:    state_nxt = ST_CMP;
      ST_CMP:     state_nxt = (slot_hit || slot_empty || probe_last) ? ST_RESP : ST_READ;
      ST_RESP:    if (conn_ready_i) state_nxt = ST_COLLECT;
      default:    state_nxt = ST_COLLECT;
    endcase
  end

  // FSM outputs: handshakes and key RAM controls
  always_comb begin
    tuple_ready_o = (state == ST_COLLECT) && !flush_pend;
    conn_valid_o  = (state == ST_RESP);
    ram_en        = (state == ST_READ);
    ram_we        = (state == ST_CMP) && slot_empty;
  end

  // Datapath: tuple assembly, probing, valid vector, occupancy and flush handling
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt   <= '0;
      key_buf    <= '0;
      idx        <= '0;
      probes     <= '0;
      valid_vec  <= '0;
      occ        <= '0;
      flush_pend <= 1'b0;
      slot_valid <= 1'b0;
      res        <= '0;
    end else begin
      if (flush_i) flush_pend <= 1'b1;
      case (state)
        ST_COLLECT: begin
          if (flush_pend) begin
            // Flush is applied only between lookups so an in-flight result is unaffected
            valid_vec  <= '0;
            occ        <= '0;
            beat_cnt   <= '0;
            flush_pend <= flush_i;
          end else if (take_beat) begin
            key_buf[int'(beat_cnt)*DATA_W +: DATA_W] <= tuple_data_i;
            beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
          end
        end
        ST_HASH: begin
          idx    <= IDX_W'(nat_fold_hash(key, IDX_W));
          probes <= '0;
        end
        ST_READ: begin
          slot_valid <= valid_vec[idx];
        end
        ST_CMP: begin
          if (slot_hit) begin
            res <= id_word | (32'h1 << RES_OK);
          end else if (slot_empty) begin
            valid_vec[idx] <= 1'b1;
            if (occ != (IDX_W+1)'(DEPTH)) occ <= occ + (IDX_W+1)'(1);
            res <= id_word | (32'h1 << RES_OK) | (32'h1 << RES_NEW);
          end else if (probe_last) begin
            res <= 32'h0;
          end else begin
            idx    <= idx + IDX_W'(1);
            probes <= probes + PRB_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign conn_data_o = res;
  assign occupancy_o = occ;

endmodule
`default_nettype wire

// File: tb/tb_nat_conn_table.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nat_conn_table
//  Purpose  : Self-checking bench: directed tests on a 32-bit/16-entry table
//             and a randomized run on a 64-bit/1024-entry table against a
//             linear-probing reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nat_conn_table;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Small instance: DATA_W=32, DEPTH=16, PROBE_MAX=4
  logic        rst_a, a_tv, a_tr, a_fl, a_cv, a_crdy;
  logic [31:0] a_td, a_cd;
  logic [4:0]  a_occ;

  // Large instance: DATA_W=64, DEPTH=1024, PROBE_MAX=32
  logic        rst_b, b_tv, b_tr, b_fl, b_cv, b_crdy;
  logic [63:0] b_td;
  logic [31:0] b_cd;
  logic [10:0] b_occ;

  nat_conn_table #(.DATA_W(32), .DEPTH(16), .PROBE_MAX(4)) dut_a (
    .clk(clk), .rst(rst_a), .tuple_valid_i(a_tv), .tuple_data_i(a_td), .tuple_ready_o(a_tr),
    .flush_i(a_fl), .conn_valid_o(a_cv), .conn_data_o(a_cd), .conn_ready_i(a_crdy),
    .occupancy_o(a_occ)
  );

  nat_conn_table #(.DATA_W(64), .DEPTH(1024), .PROBE_MAX(32)) dut_b (
    .clk(clk), .rst(rst_b), .tuple_valid_i(b_tv), .tuple_data_i(b_td), .tuple_ready_o(b_tr),
    .flush_i(b_fl), .conn_valid_o(b_cv), .conn_data_o(b_cd), .conn_ready_i(b_crdy),
    .occupancy_o(b_occ)
  );

  // Reference table for the large instance
  logic [103:0] m_key [1024];
  bit           m_val [1024];
  int           m_occ;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [103:0] mk(input logic [31:0] sip, input logic [31:0] dip,
                                      input logic [15:0] sp, input logic [15:0] dp,
                                      input logic [7:0] pr);
    return {pr, dp, sp, dip, sip};
  endfunction

  // XOR of successive w-bit slices of the key
  function automatic int fold(input logic [103:0] k, input int w);
    int h;
    logic [103:0] t, m;
    h = 0;
    m = (104'd1 << w) - 104'd1;
    for (int c = 0; c * w < 104; c++) begin
      t = (k >> (c * w)) & m;
      h = h ^ int'(t[31:0]);
    end
    return h;
  endfunction

  task automatic model_b(input logic [103:0] k, output logic [31:0] r);
    int h, s;
    h = fold(k, 10);
    r = 32'h0;
    for (int p = 0; p < 32; p++) begin
      s = (h + p) % 1024;
      if (!m_val[s]) begin
        m_val[s] = 1'b1; m_key[s] = k; m_occ++;
        r = 32'hC000_0000 | 32'(s);
        break;
      end else if (m_key[s] == k) begin
        r = 32'h8000_0000 | 32'(s);
        break;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) m_val[i] = 1'b0;
    m_occ = 0;
  endtask

  task automatic a_send(input logic [103:0] k);
    logic [127:0] kk;
    int t;
    kk = {24'd0, k};
    for (int b = 0; b < 4; b++) begin
      a_td = kk[b*32 +: 32];
      a_tv = 1'b1;
      t = 0;
      while (!a_tr && t < 50) begin @(posedge clk); #1; t++; end
      if (!a_tr) chk("a_ready_timeout", a_tr, 1);
      @(posedge clk); #1;
    end
    a_tv = 1'b0;
  endtask

  task automatic a_wait(output logic [31:0] d, output int lat);
    lat = 1;
    while (!a_cv && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!a_cv) chk("a_resp_timeout", a_cv, 1);
    d = a_cd;
    a_crdy = 1'b1;
    @(posedge clk); #1;
    a_crdy = 1'b0;
  endtask

  task automatic b_send(input logic [103:0] k);
    logic [127:0] kk;
    int t;
    kk = {24'd0, k};
    for (int b = 0; b < 2; b++) begin
      b_td = kk[b*64 +: 64];
      b_tv = 1'b1;
      t = 0;
      while (!b_tr && t < 50) begin @(posedge clk); #1; t++; end
      if (!b_tr) chk("b_ready_timeout", b_tr, 1);
      @(posedge clk); #1;
    end
    b_tv = 1'b0;
  endtask

  task automatic b_wait(output logic [31:0] d);
    int t;
    t = 0;
    while (!b_cv && t < 200) begin @(posedge clk); #1; t++; end
    if (!b_cv) chk("b_resp_timeout", b_cv, 1);
    d = b_cd;
    b_crdy = 1'b1;
    @(posedge clk); #1;
    b_crdy = 1'b0;
  endtask

  task automatic a_reset();
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [103:0] kA, kB, kX, kX2, k;
    logic [127:0] rnd;
    logic [31:0]  d, e, hold;
    logic [7:0]   pairs [5];
    logic [103:0] sent [$];
    int hA, lat, dp;

    rst_a = 1'b1; a_tv = 1'b0; a_td = '0; a_fl = 1'b0; a_crdy = 1'b0;
    rst_b = 1'b1; b_tv = 1'b0; b_td = '0; b_fl = 1'b0; b_crdy = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_ready", a_tr, 1);
    chk("rst_valid", a_cv, 0);
    chk("rst_data", a_cd, 0);
    chk("rst_occ", a_occ, 0);
    chk("rst_b_occ", b_occ, 0);
    chk("rst_b_ready", b_tr, 1);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;

    // Test 1: insert then hit, 4-cycle latency
    kA = mk(32'h0A00_0000, 32'h0808_0808, 16'd1234, 16'd80, 8'd6);
    hA = fold(kA, 4);
    a_send(kA); a_wait(d, lat);
    chk("t1_insert", d, 32'hC000_0000 | 32'(hA));
    chk("t1_insert_lat", lat, 4);
    chk("t1_occ", a_occ, 1);
    a_send(kA); a_wait(d, lat);
    chk("t1_hit", d, 32'h8000_0000 | 32'(hA));
    chk("t1_hit_lat", lat, 4);
    chk("t1_occ_hit", a_occ, 1);

    // Test 2: colliding key goes to the next slot, 6-cycle latency on second probe
    kB = mk(32'h0A00_0011, 32'h0808_0808, 16'd1234, 16'd80, 8'd6);
    a_send(kB); a_wait(d, lat);
    chk("t2_insert", d, 32'hC000_0000 | 32'((hA + 1) & 15));
    a_send(kB); a_wait(d, lat);
    chk("t2_hit", d, 32'h8000_0000 | 32'((hA + 1) & 15));
    chk("t2_hit_lat", lat, 6);
    chk("t2_occ", a_occ, 2);

    // Test 3: probe wraps from slot 15 to slot 0
    a_reset();
    chk("t3_occ_after_rst", a_occ, 0);
    dp = 0;
    while (fold(mk(32'h0A00_0000, 32'h0808_0808, 16'd1234, 16'(dp), 8'd6), 4) != 15) dp++;
    kX  = mk(32'h0A00_0000, 32'h0808_0808, 16'd1234, 16'(dp), 8'd6);
    kX2 = mk(32'h0A00_0011, 32'h0808_0808, 16'd1234, 16'(dp), 8'd6);
    a_send(kX); a_wait(d, lat);
    chk("t3_slot15", d, 32'hC000_000F);
    a_send(kX2); a_wait(d, lat);
    chk("t3_wrap", d, 32'hC000_0000);
    chk("t3_wrap_lat", lat, 6);

    // Test 4: five same-hash keys, the fifth exhausts the probe limit
    a_reset();
    pairs[0] = 8'h00; pairs[1] = 8'h11; pairs[2] = 8'h22; pairs[3] = 8'h44; pairs[4] = 8'h88;
    for (int i = 0; i < 5; i++) begin
      k = mk(32'h0A00_0000 ^ {24'd0, pairs[i]}, 32'h0808_0808, 16'd1234, 16'd80, 8'd6);
      a_send(k); a_wait(d, lat);
      if (i < 4) chk($sformatf("t4_alloc%0d", i), d, 32'hC000_0000 | 32'((hA + i) & 15));
      else begin
        chk("t4_full", d, 32'h0);
        chk("t4_full_lat", lat, 10);
      end
    end
    chk("t4_occ", a_occ, 4);

    // Test 5: backpressured response stays stable, then flush on a last beat
    a_send(kA);
    lat = 1;
    while (!a_cv && lat < 100) begin @(posedge clk); #1; lat++; end
    hold = 32'h8000_0000 | 32'(hA);
    for (int c = 0; c < 10; c++) begin
      chk("t5_hold_valid", a_cv, 1);
      chk("t5_hold_data", a_cd, hold);
      chk("t5_hold_ready", a_tr, 0);
      @(posedge clk); #1;
    end
    a_crdy = 1'b1; @(posedge clk); #1; a_crdy = 1'b0;
    chk("t5_ready_after", a_tr, 1);
    begin
      logic [127:0] kk;
      kk = {24'd0, kB};
      for (int b = 0; b < 4; b++) begin
        a_td = kk[b*32 +: 32];
        a_tv = 1'b1;
        a_fl = (b == 3);
        @(posedge clk); #1;
      end
      a_tv = 1'b0; a_fl = 1'b0;
    end
    chk("t5_flush_pend_ready", a_tr, 0);
    @(posedge clk); #1;
    chk("t5_flush_occ", a_occ, 0);
    chk("t5_flush_ready", a_tr, 1);
    repeat (4) begin
      chk("t5_no_lookup", a_cv, 0);
      @(posedge clk); #1;
    end
    a_send(kA); a_wait(d, lat);
    chk("t5_reinsert", d, 32'hC000_0000 | 32'(hA));
    chk("t5_reinsert_occ", a_occ, 1);

    // Test 6: random tuples with repeats on the wide/deep table
    for (int i = 0; i < 600; i++) begin
      if (sent.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = sent[$urandom_range(0, sent.size() - 1)];
      end else begin
        rnd = {$urandom, $urandom, $urandom, $urandom};
        k = rnd[103:0];
        sent.push_back(k);
      end
      model_b(k, e);
      b_send(k); b_wait(d);
      chk("t6_result", d, e);
      chk("t6_occ", b_occ, 11'(m_occ));
    end

    // Reset while a lookup is in flight
    rnd = {$urandom, $urandom, $urandom, $urandom};
    b_send(rnd[103:0]);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    chk("t6_rst_occ", b_occ, 0);
    chk("t6_rst_valid", b_cv, 0);
    chk("t6_rst_ready", b_tr, 1);
    model_clear();
    model_b(sent[0], e);
    b_send(sent[0]); b_wait(d);
    chk("t6_after_rst", d, e);
    chk("t6_after_rst_occ", b_occ, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
